ahb_cmd_master: RTL and testbench

AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

---
 rtl/ahb_cmd_master.sv | 180 ++++++++++++++++++
 tb/tb_ahb_cmd_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cmd_master.sv
// Command/response to AHB-Lite single-transfer master with in-order responses.
// Define AHB_CMD_MASTER_PIPE_EN to overlap address and data phases (2 outstanding).
module ahb_cmd_master (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA
);

`ifdef AHB_CMD_MASTER_PIPE_EN
  localparam logic [1:0] LIMIT = 2'd2;
`else
  localparam logic [1:0] LIMIT = 2'd1;
`endif

  logic        a_valid_q, a_valid_d;
  logic        a_bad_q, a_bad_d;
  logic        a_write_q, a_write_d;
  logic [2:0]  a_size_q, a_size_d;
  logic [31:0] a_addr_q, a_addr_d;
  logic [31:0] a_wdata_q, a_wdata_d;
  logic        d_valid_q, d_valid_d;
  logic        d_bad_q, d_bad_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [32:0] fifo_q [2];
  logic [32:0] fifo_d [2];
  logic        wp_q, wp_d, rp_q, rp_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  out_q, out_d;

  logic        misalign, d_done, a_adv, err_cyc, cancel;
  logic        idle, acc, imm, push, pop;
  logic [32:0] push_data;

  always_comb begin
    misalign = (cmd_size >= 3'd3)
             | ((cmd_size == 3'd1) & cmd_addr[0])
             | ((cmd_size == 3'd2) & (|cmd_addr[1:0]));
    // A bad token never touches the bus, so it retires without HREADY.
    d_done  = d_valid_q & (d_bad_q | HREADY);
    a_adv   = a_valid_q & (a_bad_q ? (~d_valid_q | d_done) : HREADY);
    err_cyc = d_valid_q & ~d_bad_q & HRESP;
    cancel  = err_cyc & ~HREADY & a_valid_q & ~a_bad_q;
    idle    = ~a_valid_q & ~d_valid_q;
`ifdef AHB_CMD_MASTER_PIPE_EN
    cmd_ready = ~HRESET & (out_q < LIMIT)
              & ~(a_valid_q & ~HREADY) & ~err_cyc
              & (~a_valid_q | a_adv);
`else
    cmd_ready = ~HRESET & idle & (cnt_q == 2'd0)
              & (out_q < LIMIT);
`endif
    acc  = cmd_valid & cmd_ready;
    imm  = acc & misalign & idle;
    push = d_done | imm;
    pop  = rsp_valid & rsp_ready;
    if (imm | d_bad_q)
      push_data = {1'b1, 32'h0};
    else
      push_data = {HRESP, d_write_q ? 32'h0 : HRDATA};
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_bad_d   = a_bad_q;
    a_write_d = a_write_q;
    a_size_d  = a_size_q;
    a_addr_d  = a_addr_q;
    a_wdata_d = a_wdata_q;
    if (acc) begin
      a_valid_d = ~imm;
      a_bad_d   = misalign;
      if (~imm) begin
        a_write_d = cmd_write;
        a_size_d  = cmd_size;
        a_addr_d  = cmd_addr;
        a_wdata_d = cmd_wdata;
      end
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end else if (cancel) begin
      a_bad_d = 1'b1;
    end
  end

  always_comb begin
    d_valid_d = d_valid_q;
    d_bad_d   = d_bad_q;
    d_write_d = d_write_q;
    d_wdata_d = d_wdata_q;
    if (a_adv) begin
      d_valid_d = 1'b1;
      d_bad_d   = a_bad_q;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end else if (d_done) begin
      d_valid_d = 1'b0;
    end
  end

  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    if (push)
      fifo_d[wp_q] = push_data;
    wp_d  = wp_q ^ push;
    rp_d  = rp_q ^ pop;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    out_d = out_q + {1'b0, acc} - {1'b0, pop};
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid_q <= 1'b0;
      a_bad_q   <= 1'b0;
      a_write_q <= 1'b0;
      a_size_q  <= 3'd0;
      a_addr_q  <= 32'h0;
      a_wdata_q <= 32'h0;
      d_valid_q <= 1'b0;
      d_bad_q   <= 1'b0;
      d_write_q <= 1'b0;
      d_wdata_q <= 32'h0;
      fifo_q[0] <= 33'h0;
      fifo_q[1] <= 33'h0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= 2'd0;
      out_q     <= 2'd0;
    end else begin
      a_valid_q <= a_valid_d;
      a_bad_q   <= a_bad_d;
      a_write_q <= a_write_d;
      a_size_q  <= a_size_d;
      a_addr_q  <= a_addr_d;
      a_wdata_q <= a_wdata_d;
      d_valid_q <= d_valid_d;
      d_bad_q   <= d_bad_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
    end
  end

  assign HTRANS    = (a_valid_q & ~a_bad_q) ? 2'b10 : 2'b00;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HWDATA    = (d_valid_q & d_write_q & ~d_bad_q) ? d_wdata_q : 32'h0;
  assign rsp_valid = (cnt_q != 2'd0);
  assign rsp_rdata = rsp_valid ? fifo_q[rp_q][31:0] : 32'h0;
  assign rsp_err   = rsp_valid & fifo_q[rp_q][32];

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Directed bench for ahb_cmd_master; pipelined cases run when
// AHB_CMD_MASTER_PIPE_EN is defined.
module tb_ahb_cmd_master;

`ifdef AHB_CMD_MASTER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_chk = 0;
  int n_fail = 0;

  ahb_cmd_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_size(cmd_size),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HRDATA(HRDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic cmd(input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_size  = sz;
    cmd_addr  = a;
    cmd_wdata = wd;
  endtask

  logic [2:0]  mis_sz [4];
  logic [31:0] mis_ad [4];

  initial begin
    HRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_size = 3'd0;
    cmd_addr = 32'h0; cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    mis_sz[0] = 3'd1; mis_ad[0] = 32'h1;
    mis_sz[1] = 3'd2; mis_ad[1] = 32'h2;
    mis_sz[2] = 3'd3; mis_ad[2] = 32'h0;
    mis_sz[3] = 3'd2; mis_ad[3] = 32'h3;

    repeat (2) tick();
    check("rst_htrans", 32'(HTRANS), 32'd0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("hburst", 32'(HBURST), 32'd0);
    check("hprot", 32'(HPROT), 32'h3);
    HRESET = 1'b0;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // Word write, zero wait states
    cmd(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    check("wr_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    check("wr_htrans", 32'(HTRANS), 32'd2);
    check("wr_haddr", HADDR, 32'h10);
    check("wr_hwrite", 32'(HWRITE), 32'd1);
    check("wr_hsize", 32'(HSIZE), 32'd2);
    check("wr_hwdata_a", HWDATA, 32'h0);
    tick();
    check("wr_htrans_d", 32'(HTRANS), 32'd0);
    check("wr_hwdata", HWDATA, 32'hDEADBEEF);
    check("wr_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    check("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wr_rdata", rsp_rdata, 32'h0);
    check("wr_err", 32'(rsp_err), 32'd0);
    tick();
    check("wr_popped", 32'(rsp_valid), 32'd0);
    check("wr_ready_after", 32'(cmd_ready), 32'd1);

    // Byte read, two wait states
    cmd(1'b0, 3'd0, 32'h13, 32'h0);
    tick();
    cmd_valid = 1'b0;
    check("rd_htrans", 32'(HTRANS), 32'd2);
    check("rd_haddr0", HADDR, 32'h13);
    check("rd_hsize", 32'(HSIZE), 32'd0);
    check("rd_hwrite", 32'(HWRITE), 32'd0);
    tick();
    HREADY = 1'b0;
    check("rd_haddr1", HADDR, 32'h13);
    check("rd_cmd_ready", 32'(cmd_ready), 32'(PIPE));
    tick();
    check("rd_haddr2", HADDR, 32'h13);
    check("rd_wait_rsp", 32'(rsp_valid), 32'd0);
    tick();
    HREADY = 1'b1;
    HRDATA = 32'hAB000000;
    check("rd_last_rsp", 32'(rsp_valid), 32'd0);
    tick();
    HRDATA = 32'h0;
    check("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    check("rd_rdata", rsp_rdata, 32'hAB000000);
    check("rd_err", 32'(rsp_err), 32'd0);
    tick();
    check("rd_popped", 32'(rsp_valid), 32'd0);

    // Misaligned / oversize commands never reach the bus
    for (int i = 0; i < 4; i++) begin
      cmd(1'b0, mis_sz[i], mis_ad[i], 32'h0);
      tick();
      cmd_valid = 1'b0;
      check($sformatf("mis%0d_htrans", i), 32'(HTRANS), 32'd0);
      check($sformatf("mis%0d_valid", i), 32'(rsp_valid), 32'd1);
      check($sformatf("mis%0d_err", i), 32'(rsp_err), 32'd1);
      check($sformatf("mis%0d_rdata", i), rsp_rdata, 32'h0);
      tick();
      check($sformatf("mis%0d_pop", i), 32'(rsp_valid), 32'd0);
    end

    // Aligned halfword read with response back-pressure
    cmd(1'b0, 3'd1, 32'h2, 32'h0);
    tick();
    cmd_valid = 1'b0;
    check("hw_htrans", 32'(HTRANS), 32'd2);
    check("hw_hsize", 32'(HSIZE), 32'd1);
    tick();
    HRDATA = 32'h12340000;
    rsp_ready = 1'b0;
    tick();
    HRDATA = 32'h0;
    check("hw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("hw_rdata", rsp_rdata, 32'h12340000);
    tick();
    check("hw_held", 32'(rsp_valid), 32'd1);
    check("hw_held_data", rsp_rdata, 32'h12340000);
    check("hw_cmd_ready", 32'(cmd_ready), 32'(PIPE));
    rsp_ready = 1'b1;
    tick();
    check("hw_popped", 32'(rsp_valid), 32'd0);

    // Two-cycle ERROR response on a write
    cmd(1'b1, 3'd2, 32'h40, 32'h55);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    HRESP = 1'b1;
    check("er_cmd_ready", 32'(cmd_ready), 32'd0);
    check("er_hwdata", HWDATA, 32'h55);
    tick();
    HREADY = 1'b1;
    check("er_htrans", 32'(HTRANS), 32'd0);
    tick();
    HRESP = 1'b0;
    check("er_rsp_valid", 32'(rsp_valid), 32'd1);
    check("er_err", 32'(rsp_err), 32'd1);
    check("er_rdata", rsp_rdata, 32'h0);
    tick();
    check("er_popped", 32'(rsp_valid), 32'd0);

    // Reset pulse during a wait-stated read
    cmd(1'b0, 3'd2, 32'h80, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    HREADY = 1'b0;
    tick();
    cmd(1'b0, 3'd2, 32'h84, 32'h0);
    HRESET = 1'b1;
    #1;
    check("rr_htrans", 32'(HTRANS), 32'd0);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rr_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    cmd_valid = 1'b0;
    HRESET = 1'b0;
    HREADY = 1'b1;
    HRDATA = 32'h77;
    #1;
    check("rr_ready_rel", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rr_no_rsp%0d", i), 32'(rsp_valid), 32'd0);
      check($sformatf("rr_idle%0d", i), 32'(HTRANS), 32'd0);
    end
    HRDATA = 32'h0;

`ifdef AHB_CMD_MASTER_PIPE_EN
    // Back-to-back writes, ERROR on the first cancels the second
    cmd(1'b1, 3'd2, 32'h0, 32'h11111111);
    tick();
    cmd(1'b1, 3'd2, 32'h4, 32'h22222222);
    check("pe_ready2", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    HREADY = 1'b0;
    HRESP = 1'b1;
    check("pe_htrans2", 32'(HTRANS), 32'd2);
    check("pe_haddr2", HADDR, 32'h4);
    check("pe_hwdata1", HWDATA, 32'h11111111);
    check("pe_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    HREADY = 1'b1;
    check("pe_cancel", 32'(HTRANS), 32'd0);
    tick();
    HRESP = 1'b0;
    check("pe_rsp1", 32'(rsp_valid), 32'd1);
    check("pe_err1", 32'(rsp_err), 32'd1);
    check("pe_idle", 32'(HTRANS), 32'd0);
    tick();
    check("pe_rsp2", 32'(rsp_valid), 32'd1);
    check("pe_err2", 32'(rsp_err), 32'd1);
    check("pe_rdata2", rsp_rdata, 32'h0);
    tick();
    check("pe_empty", 32'(rsp_valid), 32'd0);
    check("pe_ready_end", 32'(cmd_ready), 32'd1);

    // Outstanding limit with response back-pressure
    rsp_ready = 1'b0;
    cmd(1'b0, 3'd2, 32'h20, 32'h0);
    tick();
    cmd(1'b0, 3'd2, 32'h24, 32'h0);
    check("pl_ready_b", 32'(cmd_ready), 32'd1);
    tick();
    cmd(1'b0, 3'd2, 32'h28, 32'h0);
    HRDATA = 32'hA0;
    check("pl_full0", 32'(cmd_ready), 32'd0);
    check("pl_haddr_b", HADDR, 32'h24);
    tick();
    HRDATA = 32'hB0;
    check("pl_full1", 32'(cmd_ready), 32'd0);
    tick();
    HRDATA = 32'h0;
    check("pl_full2", 32'(cmd_ready), 32'd0);
    check("pl_rdata_a", rsp_rdata, 32'hA0);
    rsp_ready = 1'b1;
    tick();
    check("pl_reready", 32'(cmd_ready), 32'd1);
    check("pl_rdata_b", rsp_rdata, 32'hB0);
    tick();
    cmd_valid = 1'b0;
    check("pl_htrans_c", 32'(HTRANS), 32'd2);
    check("pl_haddr_c", HADDR, 32'h28);
    tick();
    HRDATA = 32'hC0;
    tick();
    HRDATA = 32'h0;
    check("pl_rdata_c", rsp_rdata, 32'hC0);
    check("pl_valid_c", 32'(rsp_valid), 32'd1);
    tick();
    check("pl_empty", 32'(rsp_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
